// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select, strobe and the 2-bit ALUOp code.
module main_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch     = 4'd0,
        StDecode    = 4'd1,
        StMemAdr    = 4'd2,
        StMemRead   = 4'd3,
        StMemWb     = 4'd4,
        StMemWrite  = 4'd5,
        StExecute   = 4'd6,
        StRComplete = 4'd7,
        StBranch    = 4'd8,
        StJump      = 4'd9
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;

        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC load only on the cycle the instruction word arrives
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = StMemAdr;
                end else if (opcode == OP_RTYPE) begin
                    state_d = StExecute;
                end else if (opcode == OP_BEQ) begin
                    state_d = StBranch;
                end else if (opcode == OP_J) begin
                    state_d = StJump;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = StFetch;
            end
            StMemWrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                // sll/srl take the dedicated shift ALUOp
                ALUOp   = (funct == 6'b000000 || funct == 6'b000010) ? 2'b11 : 2'b10;
                state_d = StRComplete;
            end
            StRComplete: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // state_q already reads FETCH under reset, so its strobes must be masked
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            PCSource    = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
        end
    end

endmodule
